// File: rtl/alu_pkg.sv
// Opcode numbering shared by the decoder, the reservation station and the ALU.
// The multiply opcodes (38-41) are only executed when ALU_MUL_EN is defined.
package alu_pkg;
  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_LUI    = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC  = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL    = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR   = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE    = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT    = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE    = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU   = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU   = 6'd10;
  localparam logic [OP_W-1:0] OP_LB     = 6'd11;
  localparam logic [OP_W-1:0] OP_LH     = 6'd12;
  localparam logic [OP_W-1:0] OP_LW     = 6'd13;
  localparam logic [OP_W-1:0] OP_LBU    = 6'd14;
  localparam logic [OP_W-1:0] OP_LHU    = 6'd15;
  localparam logic [OP_W-1:0] OP_SB     = 6'd16;
  localparam logic [OP_W-1:0] OP_SH     = 6'd17;
  localparam logic [OP_W-1:0] OP_SW     = 6'd18;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'd21;
  localparam logic [OP_W-1:0] OP_XORI   = 6'd22;
  localparam logic [OP_W-1:0] OP_ORI    = 6'd23;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI   = 6'd25;
  localparam logic [OP_W-1:0] OP_SRLI   = 6'd26;
  localparam logic [OP_W-1:0] OP_SRAI   = 6'd27;
  localparam logic [OP_W-1:0] OP_ADD    = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB    = 6'd29;
  localparam logic [OP_W-1:0] OP_SLL    = 6'd30;
  localparam logic [OP_W-1:0] OP_SLT    = 6'd31;
  localparam logic [OP_W-1:0] OP_SLTU   = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR    = 6'd33;
  localparam logic [OP_W-1:0] OP_SRL    = 6'd34;
  localparam logic [OP_W-1:0] OP_SRA    = 6'd35;
  localparam logic [OP_W-1:0] OP_OR     = 6'd36;
  localparam logic [OP_W-1:0] OP_AND    = 6'd37;
  localparam logic [OP_W-1:0] OP_MUL    = 6'd38;
  localparam logic [OP_W-1:0] OP_MULH   = 6'd39;
  localparam logic [OP_W-1:0] OP_MULHSU = 6'd40;
  localparam logic [OP_W-1:0] OP_MULHU  = 6'd41;
endpackage

// File: rtl/alu_if.sv
// RS-side issue handshake and ROB/CDB-side result handshake of alu_pipe.
// master = surrounding pipeline, slave = the ALU block.
interface alu_if #(parameter int XLEN = 32, parameter int TAG_W = 4);
  import alu_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_result;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_result, out_illegal
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_result, out_illegal
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: op/a/b -> result, illegal. Unsupported opcodes give 0.
// Config macro: ALU_MUL_EN adds MUL/MULH/MULHSU/MULHU (opcodes 38-41).
module alu_core import alu_pkg::*; #(parameter int XLEN = 32) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);

  logic [SW-1:0]   sh;
  logic [XLEN-1:0] sum;
  logic            lt_s, lt_u;

  assign sh   = b[SW-1:0];
  assign sum  = a + b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  function automatic logic [XLEN-1:0] flag(input logic c);
    return {{(XLEN-1){1'b0}}, c};
  endfunction

`ifdef ALU_MUL_EN
  // One 2*XLEN multiplier; operand extension picks the signedness.
  logic [2*XLEN-1:0] ma, mb, prod;
  always_comb begin
    ma = {{XLEN{1'b0}}, a};
    mb = {{XLEN{1'b0}}, b};
    if (op == OP_MULH || op == OP_MULHSU) ma = {{XLEN{a[XLEN-1]}}, a};
    if (op == OP_MULH)                    mb = {{XLEN{b[XLEN-1]}}, b};
    prod = ma * mb;
  end
`endif

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_LUI:                                  result = b;
      OP_AUIPC, OP_JAL, OP_LB, OP_LH, OP_LW,
      OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_ADD:                         result = sum;
      OP_JALR:                                 result = sum & {{(XLEN-1){1'b1}}, 1'b0};
      OP_BEQ:                                  result = flag(a == b);
      OP_BNE:                                  result = flag(a != b);
      OP_BLT, OP_SLT, OP_SLTI:                 result = flag(lt_s);
      OP_BGE:                                  result = flag(!lt_s);
      OP_BLTU, OP_SLTU, OP_SLTIU:              result = flag(lt_u);
      OP_BGEU:                                 result = flag(!lt_u);
      OP_SUB:                                  result = a - b;
      OP_XOR, OP_XORI:                         result = a ^ b;
      OP_OR, OP_ORI:                           result = a | b;
      OP_AND, OP_ANDI:                         result = a & b;
      OP_SLL, OP_SLLI:                         result = a << sh;
      OP_SRL, OP_SRLI:                         result = a >> sh;
      OP_SRA, OP_SRAI:                         result = $signed(a) >>> sh;
`ifdef ALU_MUL_EN
      OP_MUL:                                  result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:            result = prod[2*XLEN-1:XLEN];
`endif
      default:                                 illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: one registered execute stage (E1) feeding a DEPTH-entry result
// queue toward the ROB/CDB. Config macro ALU_MUL_EN is handled in alu_core.
module alu_pipe import alu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  alu_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic             e1_valid;
  logic [OP_W-1:0]  e1_op;
  logic [XLEN-1:0]  e1_a, e1_b, e1_result;
  logic [TAG_W-1:0] e1_tag;
  logic             e1_illegal;

  logic [XLEN-1:0]  q_result  [DEPTH];
  logic [TAG_W-1:0] q_tag     [DEPTH];
  logic             q_illegal [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic adv, accept, push, pop;

  alu_core #(.XLEN(XLEN)) u_core (
    .op(e1_op), .a(e1_a), .b(e1_b), .result(e1_result), .illegal(e1_illegal)
  );

  // Credit counts the op sitting in E1 so it always has a queue slot next edge;
  // a pop in the same cycle is deliberately not credited.
  assign bus.in_ready    = !flush && ((count + CW'(e1_valid)) < CW'(DEPTH));
  assign bus.out_valid   = (count != '0);
  assign bus.out_result  = bus.out_valid ? q_result[rd_ptr]  : '0;
  assign bus.out_tag     = bus.out_valid ? q_tag[rd_ptr]     : '0;
  assign bus.out_illegal = bus.out_valid ? q_illegal[rd_ptr] : 1'b0;

  assign adv    = rdy && !flush;
  assign accept = adv && bus.in_valid && bus.in_ready;
  assign push   = adv && e1_valid;
  assign pop    = adv && bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_valid <= 1'b0;
      e1_op    <= '0;
      e1_a     <= '0;
      e1_b     <= '0;
      e1_tag   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (rdy) begin
      if (flush) begin
        e1_valid <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        e1_valid <= accept;
        if (accept) begin
          e1_op  <= bus.in_op;
          e1_a   <= bus.in_a;
          e1_b   <= bus.in_b;
          e1_tag <= bus.in_tag;
        end
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage needs no reset: the head is masked while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_result[wr_ptr]  <= e1_result;
      q_tag[wr_ptr]     <= e1_tag;
      q_illegal[wr_ptr] <= e1_illegal;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Randomized + directed bench for alu_pipe with a cycle-level scoreboard.
// Honors ALU_MUL_EN the same way as the design build.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_if #(.XLEN(32), .TAG_W(4)) bus ();

  alu_pipe #(.XLEN(32), .TAG_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
  );

  typedef struct { bit [3:0] tag; bit [31:0] res; bit ill; } exp_t;
  exp_t vis[$];   // results the DUT should currently expose
  exp_t pend[$];  // accepted, visible after the next enabled edge

  int n_chk = 0, n_fail = 0, n_acc = 0, n_pop = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour from the opcode table, using 64-bit integer arithmetic.
  function automatic exp_t ref_alu(input int op, input bit [31:0] a, input bit [31:0] b, input bit [3:0] tag);
    exp_t e;
    longint ua, ub, sa, sb;
    int s;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    s = int'(b % 32);
    e.tag = tag; e.res = 0; e.ill = 0;
    if (op == 1) e.res = b;
    else if (op inside {2, 3, [11:19], 28}) e.res = 32'(ua + ub);
    else if (op == 4) e.res = 32'(ua + ub) & 32'hFFFF_FFFE;
    else if (op == 5) e.res = (a == b) ? 1 : 0;
    else if (op == 6) e.res = (a != b) ? 1 : 0;
    else if (op inside {7, 20, 31}) e.res = (sa < sb) ? 1 : 0;
    else if (op == 8) e.res = (sa >= sb) ? 1 : 0;
    else if (op inside {9, 21, 32}) e.res = (ua < ub) ? 1 : 0;
    else if (op == 10) e.res = (ua >= ub) ? 1 : 0;
    else if (op == 29) e.res = 32'(ua - ub);
    else if (op inside {22, 33}) e.res = a ^ b;
    else if (op inside {23, 36}) e.res = a | b;
    else if (op inside {24, 37}) e.res = a & b;
    else if (op inside {25, 30}) e.res = 32'(ua * (64'd1 << s));
    else if (op inside {26, 34}) e.res = 32'(ua / (64'd1 << s));
    else if (op inside {27, 35}) e.res = 32'(sa >>> s);
`ifdef ALU_MUL_EN
    else if (op == 38) e.res = 32'(ua * ub);
    else if (op == 39) e.res = 32'((sa * sb) >> 32);
    else if (op == 40) e.res = 32'((sa * ub) >> 32);
    else if (op == 41) e.res = 32'((ua * ub) >> 32);
`endif
    else e.ill = 1;
    return e;
  endfunction

  // Monitor: mid-cycle, compare DUT against the model, then advance the model
  // by what the coming edge should do.
  always @(negedge clk) begin
    bit exp_rdy;
    if (mon_en) begin
      chk("out_valid", bus.out_valid, vis.size() != 0);
      if (vis.size() != 0) begin
        chk("out_tag", bus.out_tag, vis[0].tag);
        chk("out_result", bus.out_result, vis[0].res);
        chk("out_illegal", bus.out_illegal, vis[0].ill);
      end else begin
        chk("idle_outputs", {bus.out_tag, bus.out_result, bus.out_illegal}, 0);
      end
      exp_rdy = !flush && (vis.size() + pend.size() < 4);
      chk("in_ready", bus.in_ready, exp_rdy);
      if (rdy) begin
        if (flush) begin
          vis.delete();
          pend.delete();
        end else begin
          if (vis.size() != 0 && bus.out_ready) begin
            void'(vis.pop_front());
            n_pop++;
          end
          if (pend.size() != 0) vis.push_back(pend.pop_front());
          if (bus.in_valid && exp_rdy) begin
            pend.push_back(ref_alu(int'(bus.in_op), bus.in_a, bus.in_b, bus.in_tag));
            n_acc++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  function automatic int rnd_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 3) return 63;
    if (r < 6) return 0;
    return $urandom_range(1, 41);
  endfunction

  task automatic set_in(input int op, input bit [31:0] a, input bit [31:0] b, input bit [3:0] tag);
    bus.in_op = 6'(op); bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
  endtask

  task automatic set_rnd();
    set_in(rnd_op(), rnd_val(), rnd_val(), 4'($urandom));
  endtask

  // Single op into an empty pipe; result checked against a spec constant.
  task automatic single(input int op, input bit [31:0] a, input bit [31:0] b,
                        input bit [3:0] tag, input bit [31:0] er, input bit ei);
    bus.out_ready = 0; bus.in_valid = 1; set_in(op, a, b, tag);
    tick(1);
    bus.in_valid = 0;
    tick(1);
    chk("dir_valid", bus.out_valid, 1);
    chk("dir_result", bus.out_result, er);
    chk("dir_tag", bus.out_tag, tag);
    chk("dir_illegal", bus.out_illegal, ei);
    bus.out_ready = 1;
    tick(1);
    bus.out_ready = 0;
  endtask

  task automatic drain();
    int guard;
    bus.in_valid = 0; bus.out_ready = 1; rdy = 1; flush = 0;
    guard = 0;
    while ((vis.size() + pend.size()) != 0 && guard < 20) begin
      tick(1);
      guard++;
    end
    chk("drain_empty", vis.size() + pend.size(), 0);
    tick(1);
  endtask

  initial begin
    int a0, p0;
    bus.in_valid = 0; bus.out_ready = 0; set_in(0, 0, 0, 0);
    tick(2);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    rst = 0;
    tick(1);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_illegal", bus.out_illegal, 0);
    mon_en = 1;

    single(28, 7, 5, 3, 12, 0);
    single(35, 32'h8000_0000, 4, 5, 32'hF800_0000, 0);
`ifdef ALU_MUL_EN
    single(38, 32'hFFFF_FFFF, 2, 6, 32'hFFFF_FFFE, 0);
`else
    single(38, 32'hFFFF_FFFF, 2, 6, 32'h0, 1);
`endif
    single(0, 32'h1234, 32'h55, 7, 32'h0, 1);
    single(4, 32'h1001, 32'h4, 8, 32'h1004, 0);
    drain();

    // back-to-back with open sink
    a0 = n_acc; p0 = n_pop;
    bus.out_ready = 1; bus.in_valid = 1;
    repeat (8) begin set_rnd(); tick(1); end
    bus.in_valid = 0;
    tick(3);
    chk("b2b_accepts", n_acc - a0, 8);
    chk("b2b_pops", n_pop - p0, 8);
    drain();

    // backpressure fills exactly DEPTH
    a0 = n_acc; p0 = n_pop;
    bus.out_ready = 0; bus.in_valid = 1;
    repeat (8) begin set_rnd(); tick(1); end
    chk("bp_accepts", n_acc - a0, 4);
    bus.in_valid = 0; bus.out_ready = 1;
    tick(6);
    chk("bp_pops", n_pop - p0, 4);
    drain();

    // flush with 3 queued + E1 busy
    p0 = n_pop;
    bus.out_ready = 0; bus.in_valid = 1;
    repeat (4) begin set_rnd(); tick(1); end
    flush = 1; set_rnd();
    tick(1);
    flush = 0; set_in(28, 100, 23, 9);
    tick(1);
    bus.in_valid = 0; bus.out_ready = 1;
    tick(4);
    chk("flush_pops", n_pop - p0, 1);
    drain();

    // rdy=0 stall mid-stream
    bus.in_valid = 1; bus.out_ready = 1;
    repeat (4) begin set_rnd(); tick(1); end
    rdy = 0; a0 = n_acc; p0 = n_pop;
    repeat (3) begin set_rnd(); tick(1); end
    chk("stall_accepts", n_acc - a0, 0);
    chk("stall_pops", n_pop - p0, 0);
    rdy = 1;
    repeat (4) begin set_rnd(); tick(1); end
    drain();

    // randomized traffic
    repeat (500) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      rdy           = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      set_rnd();
      tick(1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
